vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed-pipeline VGA controller used on the Marsohod2 board. Produces H/V sync, data-enable and pixel-coordinate requests for any timing set given by parameters, with configurable sync polarity, colour width and pixel-source latency compensation, so pattern or framebuffer readers with multi-cycle latency stay pixel-aligned. It sits between the board PLL pixel clock and the pattern/sort-display logic, driving the DAC pins directly.

---
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; define VGA_TESTBAR_EN to add iTest and an internal 8-bar colour source.
// Latency: syncs, DE, frame/line pulses and colour reach the pins LAT+1 cycles after oRequest.
// Backpressure: none; the pixel source must return colour exactly LAT cycles after oRequest.
module vga_timing_gen #(
  parameter int H_FRONT = 48,
  parameter int H_SYNC  = 112,
  parameter int H_BACK  = 248,
  parameter int H_ACT   = 1280,
  parameter int V_FRONT = 1,
  parameter int V_SYNC  = 3,
  parameter int V_BACK  = 38,
  parameter int V_ACT   = 1024,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int CW      = 10,
  parameter int LAT     = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
`ifdef VGA_TESTBAR_EN
  input  logic          iTest,
`endif
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic          oRequest,
  output logic [11:0]   oCurrent_X,
  output logic [11:0]   oCurrent_Y,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_DE,
  output logic          oFrameStart,
  output logic          oLineStart
);

  localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOT - 1);
  localparam logic [11:0] HA_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END = 12'(H_SYNC + H_BACK + H_ACT);
  localparam logic [11:0] VA_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_END = 12'(V_SYNC + V_BACK + V_ACT);

  typedef struct packed {
    logic ls;
    logic fs;
    logic de;
    logic vs;
    logic hs;
  } flags_t;

  logic [11:0] h_cnt, v_cnt;
  logic        h_act, v_act;
  flags_t      raw;
  flags_t      pipe [0:LAT];
  logic        de_tap;
  logic [CW-1:0] src_r, src_g, src_b;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!iEN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign h_act      = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
  assign v_act      = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
  assign oRequest   = h_act && v_act;
  assign oCurrent_X = oRequest ? h_cnt - HA_BEG : 12'd0;
  assign oCurrent_Y = oRequest ? v_cnt - VA_BEG : 12'd0;

  assign raw.hs = (h_cnt < 12'(H_SYNC));
  assign raw.vs = (v_cnt < 12'(V_SYNC));
  assign raw.de = oRequest;
  assign raw.fs = oRequest && (h_cnt == HA_BEG) && (v_cnt == VA_BEG);
  assign raw.ls = oRequest && (h_cnt == HA_BEG);

  // Flags are held active-high internally; polarity is applied only at the pins.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
    end else if (!iEN) begin
      for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // DE delayed by LAT marks the cycle in which the source colour is valid.
  generate
    if (LAT == 0) begin : g_tap0
      assign de_tap = raw.de;
    end else begin : g_tapn
      assign de_tap = pipe[LAT-1].de;
    end
  endgenerate

`ifdef VGA_TESTBAR_EN
  logic [2:0] bar_raw, bar_tap;

  assign bar_raw = 3'(({4'd0, oCurrent_X} << 3) / 16'(H_ACT));

  generate
    if (LAT == 0) begin : g_bar0
      assign bar_tap = bar_raw;
    end else begin : g_barn
      logic [2:0] bar_dly [0:LAT-1];
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          for (int i = 0; i < LAT; i++) bar_dly[i] <= '0;
        end else begin
          bar_dly[0] <= bar_raw;
          for (int i = 1; i < LAT; i++) bar_dly[i] <= bar_dly[i-1];
        end
      end
      assign bar_tap = bar_dly[LAT-1];
    end
  endgenerate

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  assign src_r = iTest ? {CW{~bar_tap[1]}} : iRed;
  assign src_g = iTest ? {CW{~bar_tap[2]}} : iGreen;
  assign src_b = iTest ? {CW{~bar_tap[0]}} : iBlue;
`else
  assign src_r = iRed;
  assign src_g = iGreen;
  assign src_b = iBlue;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end else if (!iEN || !de_tap) begin
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end else begin
      oVGA_R <= src_r;
      oVGA_G <= src_g;
      oVGA_B <= src_b;
    end
  end

  assign oVGA_HS     = pipe[LAT].hs ? HS_POL : ~HS_POL;
  assign oVGA_VS     = pipe[LAT].vs ? VS_POL : ~VS_POL;
  assign oVGA_DE     = pipe[LAT].de;
  assign oFrameStart = pipe[LAT].fs;
  assign oLineStart  = pipe[LAT].ls;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 10x6 raster (H 2/2/4/2, V 1/1/3/1), LAT=3, HS active high, VS active low.
module tb_vga_timing_gen;

  localparam int LAT    = 3;
  localparam int CW     = 10;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;

  typedef struct packed {
    logic          req;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          hs;
    logic          vs;
    logic          de;
    logic          fs;
    logic          ls;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } exp_t;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iEN;
  logic [CW-1:0] iRed, iGreen, iBlue;
  logic          oRequest;
  logic [11:0]   oCurrent_X, oCurrent_Y;
  logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;
  logic          oVGA_HS, oVGA_VS, oVGA_DE, oFrameStart, oLineStart;
`ifdef VGA_TESTBAR_EN
  logic          iTest = 1'b0;
`endif

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   c        = 0;

  always #5 iCLK = ~iCLK;

  vga_timing_gen #(
    .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACT(4),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .LAT(LAT)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
`ifdef VGA_TESTBAR_EN
    .iTest(iTest),
`endif
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oRequest(oRequest), .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_DE(oVGA_DE),
    .oFrameStart(oFrameStart), .oLineStart(oLineStart)
  );

  // c = enabled edges since reset/disable. Counters show state c; pins show state c-(LAT+1).
  function automatic exp_t model(input int cc);
    exp_t e;
    int h, v, p, hp, vp;
    e = '0;
    h = cc % 10;
    v = (cc / 10) % 6;
    if (h >= 4 && h < 8 && v >= 2 && v < 5) begin
      e.req = 1'b1;
      e.x   = 12'(h - 4);
      e.y   = 12'(v - 2);
    end
    e.hs = ~HS_POL;
    e.vs = ~VS_POL;
    p = cc - (LAT + 1);
    if (p >= 0) begin
      hp = p % 10;
      vp = (p / 10) % 6;
      if (hp < 2) e.hs = HS_POL;
      if (vp < 1) e.vs = VS_POL;
      if (hp >= 4 && hp < 8 && vp >= 2 && vp < 5) begin
        e.de = 1'b1;
        e.r  = CW'(hp - 4);
        e.g  = CW'(vp - 2);
        e.b  = CW'((hp - 4) ^ (vp - 2));
        e.fs = (hp == 4) && (vp == 2);
        e.ls = (hp == 4);
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Pixel source: returns X, Y and X^Y exactly LAT cycles after each request, junk otherwise.
  initial begin
    logic [11:0] hx [0:LAT];
    logic [11:0] hy [0:LAT];
    logic        hr [0:LAT];
    for (int i = 0; i <= LAT; i++) begin
      hx[i] = '0; hy[i] = '0; hr[i] = 1'b0;
    end
    iRed = '0; iGreen = '0; iBlue = '0;
    forever begin
      @(negedge iCLK);
      for (int i = LAT; i > 0; i--) begin
        hx[i] = hx[i-1]; hy[i] = hy[i-1]; hr[i] = hr[i-1];
      end
      hr[0] = oRequest; hx[0] = oCurrent_X; hy[0] = oCurrent_Y;
      if (hr[LAT]) begin
        iRed   = CW'(hx[LAT]);
        iGreen = CW'(hy[LAT]);
        iBlue  = CW'(hx[LAT] ^ hy[LAT]);
      end else begin
        iRed = '1; iGreen = '1; iBlue = '1;
      end
    end
  end

  // Monitor: one expected record per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("req",   12'(oRequest),    12'(e.req));
        chk("x",     oCurrent_X,       e.x);
        chk("y",     oCurrent_Y,       e.y);
        chk("hs",    12'(oVGA_HS),     12'(e.hs));
        chk("vs",    12'(oVGA_VS),     12'(e.vs));
        chk("de",    12'(oVGA_DE),     12'(e.de));
        chk("fs",    12'(oFrameStart), 12'(e.fs));
        chk("ls",    12'(oLineStart),  12'(e.ls));
        chk("red",   12'(oVGA_R),      12'(e.r));
        chk("green", 12'(oVGA_G),      12'(e.g));
        chk("blue",  12'(oVGA_B),      12'(e.b));
      end
    end
  end

  task automatic cyc(input logic rst_nxt, input logic en_nxt);
    @(posedge iCLK);
    if (iRST || !iEN) c = 0;
    else c++;
    #1;
    iRST = rst_nxt;
    iEN  = en_nxt;
    if (rst_nxt) c = 0;
    q.push_back(model(c));
  endtask

  initial begin
    iRST = 1'b1;
    iEN  = 1'b1;
    repeat (3)   cyc(1'b1, 1'b1);
    repeat (145) cyc(1'b0, 1'b1);   // two frames plus, stopping inside an active line
    repeat (20)  cyc(1'b0, 1'b0);   // disable mid-frame
    repeat (156) cyc(1'b0, 1'b1);   // restart from origin, again ending mid active line
    repeat (3)   cyc(1'b1, 1'b1);   // asynchronous reset mid line
    repeat (130) cyc(1'b0, 1'b1);
    @(negedge iCLK);
    #1;
    chk("drain", 12'(q.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
